// File: rtl/nand_bus_pkg.sv
// Shared types for the NAND bus arbiter: FSM encoding, idle pin levels and
// the pin-bundle layout used by every engine.
package nand_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_TURN = 2'd2
  } arb_state_e;

  localparam logic       IDLE_CEN    = 1'b1;
  localparam logic       IDLE_WEN    = 1'b1;
  localparam logic       IDLE_REN    = 1'b1;
  localparam logic       IDLE_CLE    = 1'b0;
  localparam logic       IDLE_ALE    = 1'b0;
  localparam logic       IDLE_IO_DIR = 1'b0;
  localparam logic [7:0] IDLE_IO_OUT = 8'h00;

  typedef struct packed {
    logic       cen;
    logic       wen;
    logic       ren;
    logic       cle;
    logic       ale;
    logic       wpn;
    logic       io_dir;
    logic [7:0] io_out;
  } nand_pins_t;

  // Pin levels driven while nobody owns the bus; WPn level is per-instance.
  function automatic nand_pins_t idle_pins(input logic wpn);
    nand_pins_t p;
    p.cen    = IDLE_CEN;
    p.wen    = IDLE_WEN;
    p.ren    = IDLE_REN;
    p.cle    = IDLE_CLE;
    p.ale    = IDLE_ALE;
    p.wpn    = wpn;
    p.io_dir = IDLE_IO_DIR;
    p.io_out = IDLE_IO_OUT;
    return p;
  endfunction

endpackage

// File: rtl/nand_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module nand_rr_pick
  import nand_bus_pkg::*;
#(
  parameter int unsigned NREQ = 3
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [$clog2(NREQ)-1:0] sel_c,
  output logic                    valid_c
);

  localparam int unsigned IW = $clog2(NREQ);

  logic [IW-1:0] idx;

  always_comb begin
    sel_c   = '0;
    valid_c = 1'b0;
    idx     = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      idx = IW'((int'(ptr) + k) % int'(NREQ));
      if (!valid_c && req[idx]) begin
        sel_c   = idx;
        valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nand_bus_arbiter.sv
// Round-robin owner of the shared NAND pin set: grants one engine until DONE
// or watchdog expiry, then idles the pins for a turnaround gap.
module nand_bus_arbiter
  import nand_bus_pkg::*;
#(
  parameter int unsigned NREQ     = 3,
  parameter int unsigned TURN_CYC = 2,
  parameter int unsigned MAX_HOLD = 65535,
  parameter logic        WPN_IDLE = 1'b0
) (
  input  logic                    CLK,
  input  logic                    RSTn,
  input  logic [NREQ-1:0]         REQ,
  input  logic [NREQ-1:0]         DONE,
  output logic [NREQ-1:0]         GNT,
  input  logic [NREQ-1:0]         REQ_CEn,
  input  logic [NREQ-1:0]         REQ_WEn,
  input  logic [NREQ-1:0]         REQ_REn,
  input  logic [NREQ-1:0]         REQ_CLE,
  input  logic [NREQ-1:0]         REQ_ALE,
  input  logic [NREQ-1:0]         REQ_WPn,
  input  logic [NREQ-1:0]         REQ_IO_DIR,
  input  logic [8*NREQ-1:0]       REQ_IO_OUT,
  output logic                    CEn,
  output logic                    WEn,
  output logic                    REn,
  output logic                    CLE,
  output logic                    ALE,
  output logic                    WPn,
  output logic                    IO_DIR,
  output logic [7:0]              IO_OUT,
  output logic                    BUSY,
  output logic                    TIMEOUT_ERR,
  output logic [$clog2(NREQ)-1:0] TIMEOUT_ID
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam int unsigned TW = $clog2(TURN_CYC + 1);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] sel_q, sel_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [TW-1:0] turn_q, turn_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  nand_pins_t    pins_q, pins_d;
  logic          busy_q, busy_d;
  logic          to_err_q, to_err_d;
  logic [IW-1:0] to_id_q, to_id_d;

  logic [IW-1:0] pick_sel_c;
  logic          pick_valid_c;
  nand_pins_t    own_pins_c;
  logic          done_own_c;
  logic          hold_exp_c;

  nand_rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (REQ),
    .ptr     (ptr_q),
    .sel_c   (pick_sel_c),
    .valid_c (pick_valid_c)
  );

  // Granted engine's bundle, registered next cycle onto the NAND pins.
  assign own_pins_c = {REQ_CEn[sel_q], REQ_WEn[sel_q], REQ_REn[sel_q],
                       REQ_CLE[sel_q], REQ_ALE[sel_q], REQ_WPn[sel_q],
                       REQ_IO_DIR[sel_q], REQ_IO_OUT[{sel_q, 3'b000} +: 8]};
  assign done_own_c = DONE[sel_q];
  assign hold_exp_c = (hold_q == HW'(MAX_HOLD - 1));

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    turn_d   = turn_q;
    gnt_d    = gnt_q;
    pins_d   = idle_pins(WPN_IDLE);
    to_err_d = 1'b0;
    to_id_d  = to_id_q;
    unique case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (pick_valid_c) begin
          state_d            = ST_OWN;
          sel_d              = pick_sel_c;
          gnt_d[pick_sel_c]  = 1'b1;
          hold_d             = '0;
        end
      end
      ST_OWN: begin
        pins_d = own_pins_c;
        if (done_own_c || hold_exp_c) begin
          state_d = ST_TURN;
          gnt_d   = '0;
          ptr_d   = (sel_q == IW'(NREQ - 1)) ? '0 : sel_q + IW'(1);
          turn_d  = '0;
          // DONE arriving on the expiry cycle is a clean release.
          if (!done_own_c) begin
            to_err_d = 1'b1;
            to_id_d  = sel_q;
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      ST_TURN: begin
        gnt_d = '0;
        if (turn_q == TW'(TURN_CYC - 1)) begin
          state_d = ST_IDLE;
        end else begin
          turn_d = turn_q + TW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      ptr_q    <= '0;
      hold_q   <= '0;
      turn_q   <= '0;
      gnt_q    <= '0;
      pins_q   <= idle_pins(WPN_IDLE);
      busy_q   <= 1'b0;
      to_err_q <= 1'b0;
      to_id_q  <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
      turn_q   <= turn_d;
      gnt_q    <= gnt_d;
      pins_q   <= pins_d;
      busy_q   <= busy_d;
      to_err_q <= to_err_d;
      to_id_q  <= to_id_d;
    end
  end

  assign GNT         = gnt_q;
  assign CEn         = pins_q.cen;
  assign WEn         = pins_q.wen;
  assign REn         = pins_q.ren;
  assign CLE         = pins_q.cle;
  assign ALE         = pins_q.ale;
  assign WPn         = pins_q.wpn;
  assign IO_DIR      = pins_q.io_dir;
  assign IO_OUT      = pins_q.io_out;
  assign BUSY        = busy_q;
  assign TIMEOUT_ERR = to_err_q;
  assign TIMEOUT_ID  = to_id_q;

endmodule

// File: tb/tb_nand_bus_arbiter.sv
// Bench for nand_bus_arbiter: directed scenarios plus random traffic, all
// checked every cycle against an owner/age/gap reference model.
module tb_nand_bus_arbiter;

  localparam int unsigned NREQ     = 3;
  localparam int unsigned TURN_CYC = 2;
  localparam int unsigned MAX_HOLD = 16;
  localparam logic        WPN_IDLE = 1'b0;

  logic              CLK = 1'b0;
  logic              RSTn;
  logic [NREQ-1:0]   REQ, DONE, GNT;
  logic [NREQ-1:0]   REQ_CEn, REQ_WEn, REQ_REn, REQ_CLE, REQ_ALE, REQ_WPn, REQ_IO_DIR;
  logic [8*NREQ-1:0] REQ_IO_OUT;
  logic              CEn, WEn, REn, CLE, ALE, WPn, IO_DIR;
  logic [7:0]        IO_OUT;
  logic              BUSY, TIMEOUT_ERR;
  logic [1:0]        TIMEOUT_ID;

  always #5 CLK = ~CLK;

  nand_bus_arbiter #(
    .NREQ(NREQ), .TURN_CYC(TURN_CYC), .MAX_HOLD(MAX_HOLD), .WPN_IDLE(WPN_IDLE)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .REQ(REQ), .DONE(DONE), .GNT(GNT),
    .REQ_CEn(REQ_CEn), .REQ_WEn(REQ_WEn), .REQ_REn(REQ_REn), .REQ_CLE(REQ_CLE),
    .REQ_ALE(REQ_ALE), .REQ_WPn(REQ_WPn), .REQ_IO_DIR(REQ_IO_DIR), .REQ_IO_OUT(REQ_IO_OUT),
    .CEn(CEn), .WEn(WEn), .REn(REn), .CLE(CLE), .ALE(ALE), .WPn(WPn),
    .IO_DIR(IO_DIR), .IO_OUT(IO_OUT), .BUSY(BUSY),
    .TIMEOUT_ERR(TIMEOUT_ERR), .TIMEOUT_ID(TIMEOUT_ID)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: who owns the bus, for how long, and how much gap is left.
  int              m_owner, m_age, m_gap, m_ptr;
  logic [NREQ-1:0] e_gnt;
  logic [14:0]     e_pins;
  logic            e_busy, e_err;
  logic [1:0]      e_id;

  function automatic logic [14:0] idle_v();
    return {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, WPN_IDLE, 1'b0, 8'h00};
  endfunction

  function automatic logic [14:0] bundle(input int i);
    return {REQ_CEn[i], REQ_WEn[i], REQ_REn[i], REQ_CLE[i], REQ_ALE[i],
            REQ_WPn[i], REQ_IO_DIR[i], REQ_IO_OUT[i*8 +: 8]};
  endfunction

  function automatic logic [14:0] pins_obs();
    return {CEn, WEn, REn, CLE, ALE, WPn, IO_DIR, IO_OUT};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_age = 0; m_gap = 0; m_ptr = 0;
    e_gnt = '0; e_pins = idle_v(); e_busy = 1'b0; e_err = 1'b0; e_id = 2'd0;
  endtask

  task automatic model_step();
    e_err = 1'b0;
    if (m_owner >= 0) begin
      e_pins = bundle(m_owner);
      if (DONE[m_owner] || m_age == int'(MAX_HOLD) - 1) begin
        if (!DONE[m_owner]) begin
          e_err = 1'b1;
          e_id  = 2'(m_owner);
        end
        m_ptr   = (m_owner + 1) % int'(NREQ);
        m_owner = -1;
        m_gap   = int'(TURN_CYC);
      end else begin
        m_age++;
      end
    end else begin
      e_pins = idle_v();
      if (m_gap > 0) m_gap--;
      else begin
        for (int k = 0; k < int'(NREQ); k++) begin
          if (m_owner < 0 && REQ[(m_ptr + k) % int'(NREQ)]) begin
            m_owner = (m_ptr + k) % int'(NREQ);
            m_age   = 0;
          end
        end
      end
    end
    e_gnt = '0;
    if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
    e_busy = (m_owner >= 0) || (m_gap > 0);
  endtask

  task automatic check_all();
    chk("gnt",      32'(GNT),         32'(e_gnt));
    chk("pins",     32'(pins_obs()),  32'(e_pins));
    chk("busy",     32'(BUSY),        32'(e_busy));
    chk("tout_err", 32'(TIMEOUT_ERR), 32'(e_err));
    chk("tout_id",  32'(TIMEOUT_ID),  32'(e_id));
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic step();
    model_step();
    @(posedge CLK);
    #1;
    cyc++;
    check_all();
    @(negedge CLK);
  endtask

  task automatic rand_pins();
    REQ_CEn    = 3'($urandom);
    REQ_WEn    = 3'($urandom);
    REQ_REn    = 3'($urandom);
    REQ_CLE    = 3'($urandom);
    REQ_ALE    = 3'($urandom);
    REQ_WPn    = 3'($urandom);
    REQ_IO_DIR = 3'($urandom);
    REQ_IO_OUT = 24'($urandom);
  endtask

  // Let the current owner finish and wait for the bus to go idle.
  task automatic drain();
    for (int s = 0; s < 80 && (m_owner >= 0 || m_gap > 0); s++) begin
      DONE = '0;
      if (m_owner >= 0 && m_age >= 3) DONE[m_owner] = 1'b1;
      step();
    end
    DONE = '0;
    chk("drain_idle", 32'(BUSY), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int              q[$];
    int              rr_exp[5];
    logic [NREQ-1:0] prev;
    int              fall, own_cycles, errs, budget;
    logic            seen_next;

    rr_exp = '{1, 2, 4, 1, 2};
    RSTn = 1'b0; REQ = '0; DONE = '0;
    REQ_CEn = '1; REQ_WEn = '1; REQ_REn = '1; REQ_CLE = '0; REQ_ALE = '0;
    REQ_WPn = '0; REQ_IO_DIR = '0; REQ_IO_OUT = '0;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_gnt",  32'(GNT),         32'(0));
    chk("rst_pins", 32'(pins_obs()),  32'(15'h7000));
    chk("rst_busy", 32'(BUSY),        32'(0));
    chk("rst_err",  32'(TIMEOUT_ERR), 32'(0));
    chk("rst_id",   32'(TIMEOUT_ID),  32'(0));
    RSTn = 1'b1;
    @(negedge CLK);

    // Round-robin with all engines requesting, DONE 10 cycles into each grant.
    REQ = 3'b111; prev = '0; fall = -1;
    for (int s = 0; s < 300 && q.size() < 5; s++) begin
      DONE = '0;
      if (m_owner >= 0 && m_age == 9) DONE[m_owner] = 1'b1;
      rand_pins();
      step();
      if (GNT != 0 && prev == 0) begin
        q.push_back(int'(GNT));
        if (fall >= 0) chk("rr_gap", 32'(cyc - fall), 32'(TURN_CYC + 1));
      end
      if (GNT == 0 && prev != 0) fall = cyc;
      prev = GNT;
    end
    DONE = '0; REQ = '0;
    chk("rr_count", 32'(q.size()), 32'(5));
    for (int i = 0; i < q.size() && i < 5; i++) chk("rr_order", 32'(q[i]), 32'(rr_exp[i]));
    drain();

    // Single request from engine 1 with fixed pin values.
    REQ_CEn = 3'b101; REQ_WEn = 3'b111; REQ_REn = 3'b111; REQ_CLE = 3'b010;
    REQ_ALE = 3'b000; REQ_WPn = 3'b010; REQ_IO_DIR = 3'b000; REQ_IO_OUT = 24'h0;
    REQ = 3'b010;
    step();
    chk("single_gnt", 32'(GNT), 32'(3'b010));
    step();
    chk("single_cen", 32'(CEn), 32'(0));
    chk("single_cle", 32'(CLE), 32'(1));
    chk("single_io",  32'(IO_OUT), 32'(8'h00));
    for (int s = 0; s < 20 && !(m_owner == 1 && m_age == 8); s++) step();
    DONE = 3'b010; REQ = '0;
    step();
    DONE = '0;
    chk("single_rel_gnt", 32'(GNT), 32'(0));
    chk("single_rel_cen", 32'(CEn), 32'(0));
    step();
    chk("single_idle_cen", 32'(CEn), 32'(1));
    for (int s = 1; s < int'(TURN_CYC); s++) step();
    chk("single_busy_low", 32'(BUSY), 32'(0));

    // Foreign DONE is ignored; the owner's DONE releases.
    REQ = 3'b001;
    step();
    chk("foreign_gnt0", 32'(GNT), 32'(3'b001));
    DONE = 3'b100;
    step();
    chk("foreign_hold", 32'(GNT), 32'(3'b001));
    DONE = 3'b001; REQ = '0;
    step();
    DONE = '0;
    chk("own_done_rel", 32'(GNT), 32'(0));
    drain();

    // Watchdog: engine 2 never finishes.
    REQ = 3'b101; own_cycles = 0; errs = 0; seen_next = 1'b0; budget = 0;
    while (!seen_next && budget < 80) begin
      rand_pins();
      step();
      budget++;
      if (GNT == 3'b100) own_cycles++;
      if (TIMEOUT_ERR) errs++;
      if (GNT == 3'b001) seen_next = 1'b1;
    end
    chk("wd_next_gnt",   32'(GNT),        32'(3'b001));
    chk("wd_own_cycles", 32'(own_cycles), 32'(MAX_HOLD));
    chk("wd_err_pulses", 32'(errs),       32'(1));
    chk("wd_id",         32'(TIMEOUT_ID), 32'(2));

    // DONE on the expiry cycle wins over the watchdog.
    REQ = '0; budget = 0;
    while (m_owner == 0 && m_age < int'(MAX_HOLD) - 1 && budget < 40) begin
      step();
      budget++;
    end
    DONE = 3'b001;
    step();
    DONE = '0;
    chk("dto_gnt", 32'(GNT),         32'(0));
    chk("dto_err", 32'(TIMEOUT_ERR), 32'(0));
    chk("dto_id",  32'(TIMEOUT_ID),  32'(2));
    drain();

    // Random traffic.
    for (int s = 0; s < 400; s++) begin
      REQ = 3'($urandom);
      for (int b = 0; b < int'(NREQ); b++) DONE[b] = ($urandom_range(0, 5) == 0);
      rand_pins();
      step();
    end
    REQ = '0; DONE = '0;
    drain();

    // Asynchronous reset while engine 0 drives the pins.
    REQ_CEn = 3'b110; REQ_IO_DIR = 3'b001; REQ_WPn = 3'b001;
    REQ = 3'b001; budget = 0;
    while (m_owner != 0 && budget < 20) begin
      step();
      budget++;
    end
    step();
    chk("ar_cen_before", 32'(CEn), 32'(0));
    #2 RSTn = 1'b0;
    #1;
    chk("ar_cen",    32'(CEn),    32'(1));
    chk("ar_gnt",    32'(GNT),    32'(0));
    chk("ar_io_dir", 32'(IO_DIR), 32'(0));
    chk("ar_wpn",    32'(WPn),    32'(WPN_IDLE));
    chk("ar_busy",   32'(BUSY),   32'(0));
    model_reset();
    @(negedge CLK);
    RSTn = 1'b1;
    REQ = 3'b111;
    step();
    chk("ar_regrant", 32'(GNT), 32'(3'b001));
    REQ = '0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
